uart_tx_fifo: RTL

Consumes the 9-bit UART strobe bus from the RV32IM core (uart_out: bit 8 = one-cycle valid, bits 7:0 = byte) and buffers bytes in a FIFO. It serialises them onto a single 8N1 TX line at a fixed baud divider. The core may issue a byte on any cycle, so the FIFO absorbs bursts. Status outputs allow later MMIO exposure of a real flag at 0xfff1.

---
 rtl/uart_tx_fifo_pkg.sv | 36 +++
 rtl/uart_tx_fifo_if.sv | 50 +++++
 rtl/uart_tx_fifo_sync_fifo.sv | 77 +++++++
 rtl/uart_tx_fifo.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_pkg
// Shared definitions for the buffered UART transmitter. The RV32IM core and
// this block both import these values so that they agree on the MMIO
// addresses, the default baud divider and the transmitter state encoding.
//
// Contents:
//   tx_state_t            transmitter FSM states (IDLE/START/DATA/STOP)
//   uart_strobe_t         view of the core's 9-bit uart_out strobe bus
//   DEFAULT_CLKS_PER_BIT  100 MHz / 115200 baud
//   DEFAULT_FIFO_DEPTH    default number of queued bytes
//   UART_DATA_ADDR        MMIO address the core writes bytes to
//   UART_STATUS_ADDR      MMIO address reserved for the status flag
// ---------------------------------------------------------------------------
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Bit 8 is a one-cycle write strobe, bits 7:0 the byte to transmit.
  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } uart_strobe_t;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_FIFO_DEPTH   = 16;

  localparam logic [15:0] UART_DATA_ADDR   = 16'hfff0;
  localparam logic [15:0] UART_STATUS_ADDR = 16'hfff1;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
// Bundles the core-facing strobe bus and the transmitter's line/status
// outputs.
//
// Signals:
//   uart_in     [8] write strobe, [7:0] byte      (core -> transmitter)
//   tx          serial line, idle high             (transmitter -> pins)
//   busy        frame currently on the line
//   fifo_full   queue holds FIFO_DEPTH bytes
//   fifo_count  bytes queued, excluding the one being shifted
//   overflow    sticky: a byte was dropped because the queue was full
//
// Modports:
//   master  the core side (drives uart_in, observes status)
//   slave   the transmitter (uart_tx_fifo)
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [8:0]       uart_in;
  logic             tx;
  logic             busy;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             overflow;

  modport master (
    output uart_in,
    input  tx,
    input  busy,
    input  fifo_full,
    input  fifo_count,
    input  overflow
  );

  modport slave (
    input  uart_in,
    output tx,
    output busy,
    output fifo_full,
    output fifo_count,
    output overflow
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with combinational read of the head entry.
//
// Ports:
//   clock, reset_n  system clock, asynchronous active-low reset
//   push, wr_data   write wr_data at the tail
//   pop             drop the head entry (rd_data is valid before the edge)
//   rd_data         current head entry
//   full, empty     occupancy flags
//   count           number of stored entries (0..DEPTH)
//
// A push while full is accepted only when a pop happens on the same edge;
// the write then lands in the slot the pop is vacating. A pop while empty
// is ignored.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = ADDR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage has no reset; only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Buffered 8N1 UART transmitter. Bytes strobed in by the core are queued in
// a sync_fifo and shifted out LSB first at a fixed baud divider.
//
// Ports:
//   clock    system clock, rising edge
//   reset_n  asynchronous active-low reset (aborts any frame in flight)
//   bus      uart_tx_fifo_if.slave: uart_in strobe bus in; tx, busy,
//            fifo_full, fifo_count and sticky overflow out
//
// A frame is START (low), 8 data bits, STOP (high), each CLKS_PER_BIT
// cycles, 10*CLKS_PER_BIT cycles in total. When the queue still holds a
// byte at the end of STOP, the next START follows with no idle gap.
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter  int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter  int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic           clock,
  input  logic           reset_n,
  uart_tx_fifo_if.slave  bus
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_strobe_t      strobe;
  tx_state_t         state_q;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              tx_q;
  logic              busy_q;
  logic              overflow_q;

  logic              baud_end;
  logic              push;
  logic              pop;
  logic [7:0]        head_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign strobe   = bus.uart_in;
  assign baud_end = (baud_cnt == BAUD_LAST);

  // The head is taken either from IDLE or at the last cycle of STOP, which
  // is what lets back-to-back frames run without an idle bit between them.
  assign pop  = !fifo_empty &&
                ((state_q == IDLE) || ((state_q == STOP) && baud_end));
  assign push = strobe.valid && (!fifo_full || pop);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (strobe.data),
    .rd_data (head_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A strobe that finds the queue full with no pop on the same edge loses
  // its byte; the flag stays set until reset so software can notice later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (strobe.valid && fifo_full && !pop) begin
      overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          baud_cnt <= '0;
          if (!fifo_empty) begin
            shift_reg <= head_data;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
          end else begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx_q     <= shift_reg[0];
            bit_idx  <= '0;
            state_q  <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q    <= shift_reg[bit_idx + 3'd1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (!fifo_empty) begin
              shift_reg <= head_data;
              tx_q      <= 1'b0;
              state_q   <= START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          baud_cnt <= '0;
          tx_q     <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = overflow_q;

endmodule
